// File: rtl/present_sbox_sched_pkg.sv
// Shared types for the masked PRESENT S-box layer scheduler.
// Provides the nibble count, nibble index type, FSM state encoding and a
// nibble extraction helper.
package present_pkg;

    localparam int unsigned NIBBLES = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned STATE_W = 64;

    typedef logic [IDX_W-1:0] nib_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fsm_t;

    // Nibble i lives at bits [4i+3:4i] of a share.
    function automatic logic [3:0] get_nib(input logic [STATE_W-1:0] s, input nib_idx_t i);
        return s[{i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/present_sbox_sched_if.sv
// Bus bundle between the round controller / masked gadget and the scheduler.
// slave  : scheduler view (control + randomness in, gadget results in).
// master : environment view (round controller, RNG and gadget).
interface present_sbox_sched_if #(
    parameter int unsigned RND_W = 64
);
    logic              start;
    logic [63:0]       load0;
    logic [63:0]       load1;
    logic [63:0]       state0;
    logic [63:0]       state1;
    logic              busy;
    logic              done;
    logic              rnd_valid;
    logic [RND_W-1:0]  rnd;
    logic              rnd_ack;
    logic [3:0]        sbox_in0;
    logic [3:0]        sbox_in1;
    logic [RND_W-1:0]  r_out;
    logic [3:0]        sbox_out0;
    logic [3:0]        sbox_out1;

    modport slave (
        input  start, load0, load1, rnd_valid, rnd, sbox_out0, sbox_out1,
        output state0, state1, busy, done, rnd_ack, sbox_in0, sbox_in1, r_out
    );

    modport master (
        output start, load0, load1, rnd_valid, rnd, sbox_out0, sbox_out1,
        input  state0, state1, busy, done, rnd_ack, sbox_in0, sbox_in1, r_out
    );
endinterface

// File: rtl/present_sbox_sched_inflight_tracker.sv
// LATENCY-deep valid+index shift register mirroring the gadget pipeline.
// Ports: clk, rst (sync, active-high); i_vld/i_idx enter at the head every
// cycle; o_tail_vld/o_tail_idx show the entry leaving the pipeline.
module present_inflight_tracker
    import present_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_vld,
    input  nib_idx_t i_idx,
    output logic     o_tail_vld,
    output nib_idx_t o_tail_idx
);

    logic [LATENCY-1:0] r_vld;
    nib_idx_t           r_idx [LATENCY];

    // Valid chain: cleared on reset so in-flight results are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_vld;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // Index chain: only meaningful alongside a set valid bit.
    always_ff @(posedge clk) begin
        r_idx[0] <= i_idx;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            r_idx[i] <= r_idx[i-1];
        end
    end

    assign o_tail_vld = r_vld[LATENCY-1];
    assign o_tail_idx = r_idx[LATENCY-1];

endmodule

// File: rtl/present_sbox_sched.sv
// Issue/writeback scheduler for the nibble-serial two-share masked PRESENT
// S-box layer. Holds both shares, issues one nibble per cycle when rnd_valid,
// and writes each gadget result back into its originating nibble slot.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries start,
// load0/1, state0/1, busy, done, rnd_valid/rnd/rnd_ack, sbox_in0/1, r_out,
// sbox_out0/1.
module present_sbox_sched
    import present_pkg::*;
#(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned RND_W   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    present_sbox_sched_if.slave  bus
);

    fsm_t              r_state;
    nib_idx_t          r_issue_idx;
    logic [CNT_W-1:0]  r_wb_cnt;
    logic [63:0]       r_state0;
    logic [63:0]       r_state1;
    logic              r_busy;
    logic              r_done;

    logic              w_fire;
    logic              w_tail_vld;
    nib_idx_t          w_tail_idx;

    assign w_fire = (r_state == RUN) && bus.rnd_valid;

    present_inflight_tracker #(
        .LATENCY (LATENCY)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .i_vld      (w_fire),
        .i_idx      (r_issue_idx),
        .o_tail_vld (w_tail_vld),
        .o_tail_idx (w_tail_idx)
    );

    // Gadget inputs track the issue slot; randomness is gated so it is never reused.
    assign bus.sbox_in0 = get_nib(r_state0, r_issue_idx);
    assign bus.sbox_in1 = get_nib(r_state1, r_issue_idx);
    assign bus.r_out    = w_fire ? bus.rnd : '0;
    assign bus.rnd_ack  = w_fire;
    assign bus.state0   = r_state0;
    assign bus.state1   = r_state1;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

    // Layer FSM with share registers and writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_issue_idx <= '0;
            r_wb_cnt    <= '0;
            r_state0    <= '0;
            r_state1    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_tail_vld) begin
                r_state0[{w_tail_idx, 2'b00} +: 4] <= bus.sbox_out0;
                r_state1[{w_tail_idx, 2'b00} +: 4] <= bus.sbox_out1;
                r_wb_cnt <= r_wb_cnt + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state     <= RUN;
                        r_busy      <= 1'b1;
                        r_state0    <= bus.load0;
                        r_state1    <= bus.load1;
                        r_issue_idx <= '0;
                        r_wb_cnt    <= '0;
                    end
                end
                RUN: begin
                    if (w_fire) begin
                        r_issue_idx <= r_issue_idx + IDX_W'(1);
                        if (r_issue_idx == IDX_W'(NIBBLES - 1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Leave on the edge that completes the 16th writeback.
                    if ((w_tail_vld && (r_wb_cnt == CNT_W'(NIBBLES - 1))) ||
                        (r_wb_cnt == CNT_W'(NIBBLES))) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_present_sbox_sched.sv
// Scoreboard bench for present_sbox_sched: three lanes (LATENCY 1, 3, 8)
// share stimulus; each lane has a behavioural masked gadget and a monitor.
module tb_present_sbox_sched;

    localparam int NL = 3;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 8);
    endfunction

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    typedef struct {
        logic [3:0] idx;
        int         due;
    } iss_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        poke_done;
    logic [63:0] load0;
    logic [63:0] load1;
    logic        rnd_valid;
    logic [63:0] rnd;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    exp_t        exp_q [NL][$];
    logic [63:0] o_s0   [NL];
    logic [63:0] o_s1   [NL];
    logic        o_busy [NL];
    logic        o_done [NL];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_ff @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] t;
        t = 64'h21748FE3DA09B65C;
        return t[{x, 2'b00} +: 4];
    endfunction

    // Unmasked reference: the S-box applied independently to each nibble.
    function automatic logic [63:0] layer(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[i*4 +: 4] = sbox(x[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input int lane, input bit ok,
                       input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s lane=%0d got=%0h want=%0h", nm, lane, act, exp);
        end
    endtask

    for (genvar k = 0; k < NL; k++) begin : g_lane
        localparam int LAT = lat_of(k);

        present_sbox_sched_if #(.RND_W(64)) bus ();

        assign bus.start     = start | (poke_done & bus.done);
        assign bus.load0     = load0;
        assign bus.load1     = load1;
        assign bus.rnd_valid = rnd_valid;
        assign bus.rnd       = rnd;
        assign o_s0[k]       = bus.state0;
        assign o_s1[k]       = bus.state1;
        assign o_busy[k]     = bus.busy;
        assign o_done[k]     = bus.done;

        present_sbox_sched #(.LATENCY(LAT), .RND_W(64)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Masked gadget model: out0 = S(x) ^ m, out1 = m, LAT cycles later.
        logic [3:0] p0 [LAT];
        logic [3:0] p1 [LAT];
        always_ff @(posedge clk) begin
            p0[0] <= sbox(bus.sbox_in0 ^ bus.sbox_in1) ^ bus.r_out[3:0];
            p1[0] <= bus.r_out[3:0];
            for (int i = 1; i < LAT; i++) begin
                p0[i] <= p0[i-1];
                p1[i] <= p1[i-1];
            end
        end
        assign bus.sbox_out0 = p0[LAT-1];
        assign bus.sbox_out1 = p1[LAT-1];

        // Monitor: issue/writeback ordering, randomness gating, layer result.
        initial begin
            iss_t iq[$];
            iss_t ie;
            exp_t e;
            int   iss;
            int   acks;
            int   wbs;
            iss = 0; acks = 0; wbs = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    iq.delete();
                    iss = 0; acks = 0; wbs = 0;
                end else begin
                    chk("r_out", k, bus.r_out == (bus.rnd_ack ? rnd : 64'h0), bus.r_out,
                        bus.rnd_ack ? rnd : 64'h0);
                    if (bus.rnd_ack) begin
                        chk("ack_without_valid", k, rnd_valid == 1'b1, 64'(rnd_valid), 64'h1);
                        iq.push_back('{idx: 4'(iss), due: cyc + LAT});
                        iss++;
                        acks++;
                    end
                    if (u_dut.w_tail_vld) begin
                        wbs++;
                        if (iq.size() == 0) begin
                            chk("spurious_wb", k, 1'b0, 64'(u_dut.w_tail_idx), 64'h0);
                        end else begin
                            ie = iq.pop_front();
                            chk("wb_idx", k, u_dut.w_tail_idx == ie.idx,
                                64'(u_dut.w_tail_idx), 64'(ie.idx));
                            chk("wb_cycle", k, cyc == ie.due, 64'(cyc), 64'(ie.due));
                        end
                    end
                    if (bus.done) begin
                        if (exp_q[k].size() == 0) begin
                            chk("unexpected_done", k, 1'b0, 64'(cyc), 64'h0);
                        end else begin
                            e = exp_q[k].pop_front();
                            chk("done_cycle", k, cyc == e.due, 64'(cyc), 64'(e.due));
                            chk("result", k, (bus.state0 ^ bus.state1) == e.res,
                                bus.state0 ^ bus.state1, e.res);
                        end
                        chk("ack_count", k, acks == 16, 64'(acks), 64'd16);
                        chk("wb_count", k, wbs == 16, 64'(wbs), 64'd16);
                        iss = 0; acks = 0; wbs = 0;
                    end
                end
            end
        end
    end

    function automatic bit all_empty();
        for (int k = 0; k < NL; k++) if (exp_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // One layer; b1/b2 force bubbles at t+b, rmode randomises rnd_valid,
    // abort_at asserts rst at t+abort_at, poke re-pulses start in RUN and DONE.
    task automatic run_layer(input logic [63:0] l0, input logic [63:0] l1,
                             input int b1, input int b2, input bit rmode,
                             input int abort_at, input bit poke);
        logic [63:0] exp_res;
        int t, j, fires, nb, n;
        bit v;
        @(posedge clk); #1;
        start = 1'b1; load0 = l0; load1 = l1; rnd_valid = 1'b1; rnd = r64();
        t = cyc;
        exp_res = layer(l0 ^ l1);
        @(posedge clk); #1;
        fires = 0; nb = 0; j = 1;
        while (fires < 16) begin
            if (j == abort_at) begin
                start = 1'b0;
                rst = 1'b1;
                for (int k = 0; k < NL; k++) exp_q[k].delete();
                @(posedge clk); #1;
                for (int k = 0; k < NL; k++) begin
                    chk("abort_busy", k, o_busy[k] == 1'b0, 64'(o_busy[k]), 64'h0);
                    chk("abort_state", k, (o_s0[k] | o_s1[k]) == 64'h0, o_s0[k] | o_s1[k], 64'h0);
                    chk("abort_done", k, o_done[k] == 1'b0, 64'(o_done[k]), 64'h0);
                end
                rst = 1'b0;
                return;
            end
            v = !(j == b1 || j == b2) && (!rmode || ($urandom_range(0, 3) != 0));
            rnd_valid = v;
            rnd = r64();
            start = poke && (j == 5);
            load0 = r64(); load1 = r64();
            if (v) fires++; else nb++;
            if (fires == 16) begin
                for (int k = 0; k < NL; k++)
                    exp_q[k].push_back('{res: exp_res, due: t + 17 + lat_of(k) + nb});
            end
            @(posedge clk); #1;
            j++;
        end
        start = 1'b0;
        poke_done = poke;
        n = 0;
        while (!all_empty() && n < 60) begin
            rnd_valid = $urandom_range(0, 1) != 0;
            rnd = r64();
            load0 = r64(); load1 = r64();
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", -1, all_empty(), 64'(n), 64'd60);
        for (int k = 0; k < NL; k++) exp_q[k].delete();
        repeat (3) @(posedge clk);
        #1;
        poke_done = 1'b0;
        if (poke) begin
            for (int k = 0; k < NL; k++) begin
                chk("ignored_start_busy", k, o_busy[k] == 1'b0, 64'(o_busy[k]), 64'h0);
                chk("no_recapture", k, (o_s0[k] ^ o_s1[k]) == exp_res, o_s0[k] ^ o_s1[k], exp_res);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; poke_done = 1'b0;
        load0 = '0; load1 = '0; rnd_valid = 1'b1; rnd = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) begin
            chk("rst_state0", k, o_s0[k] == 64'h0, o_s0[k], 64'h0);
            chk("rst_state1", k, o_s1[k] == 64'h0, o_s1[k], 64'h0);
            chk("rst_busy", k, o_busy[k] == 1'b0, 64'(o_busy[k]), 64'h0);
            chk("rst_done", k, o_done[k] == 1'b0, 64'(o_done[k]), 64'h0);
        end
        rst = 1'b0;

        run_layer(64'h0123456789ABCDEF, 64'h0, -1, -1, 1'b0, 0, 1'b0);
        run_layer(64'h0123456789ABCDEF, r64(), -1, -1, 1'b0, 0, 1'b0);
        run_layer(r64(), r64(), 3, 10, 1'b0, 0, 1'b0);
        run_layer(r64(), r64(), -1, -1, 1'b0, 0, 1'b1);
        run_layer(r64(), r64(), -1, -1, 1'b0, 8, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        run_layer(r64(), r64(), -1, -1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 6; i++) run_layer(r64(), r64(), -1, -1, 1'b1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
